ac_compressor_sequencer: RTL



---
 rtl/ac_compressor_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ac_compressor_sequencer.sv
// Compressor/fan sequencer: pre-start, minimum on-time, run-down, restart lockout, fan ramp.
// Latency: decisions take effect on the edge that samples the inputs; the fan steps every RAMP_CYCLES.
// No backpressure; clk/reset in, mode + measured/setpoint temperatures in, compressor_on/fan_speed/seq_state out.
module ac_compressor_sequencer #(
    parameter int PRESTART_CYCLES = 4,
    parameter int MIN_ON_CYCLES   = 16,
    parameter int RUNDOWN_CYCLES  = 8,
    parameter int LOCKOUT_CYCLES  = 32,
    parameter int RAMP_CYCLES     = 2,
    parameter int HYST            = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode_select,
    input  logic [6:0] temperature,
    input  logic [6:0] temperature_registered,
    output logic       compressor_on,
    output logic [2:0] fan_speed,
    output logic [2:0] seq_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRESTART = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_RUNDOWN  = 3'd3;
    localparam logic [2:0] S_LOCKOUT  = 3'd4;

    localparam int CW = 16;
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRESTART_CYCLES - 1);
    localparam logic [CW-1:0] MIN_LAST  = CW'(MIN_ON_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST   = CW'(RUNDOWN_CYCLES - 1);
    localparam logic [CW-1:0] LO_LAST   = CW'(LOCKOUT_CYCLES - 1);
    localparam logic [CW-1:0] RAMP_LAST = CW'(RAMP_CYCLES - 1);
    localparam logic [7:0]    HYST_V    = 8'(HYST);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] ramp_q, ramp_d;
    logic [2:0]    fan_q, fan_d;
    logic          comp_q, comp_d;

    logic [7:0] temp_w, setp_w, diff;
    logic       start_demand, stop_cond, min_on_done;
    logic [2:0] run_target, fan_target;

    // Widen to 8 bits so the subtraction and compares cannot wrap.
    assign temp_w = {1'b0, temperature};
    assign setp_w = {1'b0, temperature_registered};
    assign diff   = (temp_w > setp_w) ? (temp_w - setp_w) : 8'd0;

    assign stop_cond   = (mode_select == 2'b00) || (temp_w <= setp_w);
    assign min_on_done = (cnt_q == MIN_LAST);

    always_comb begin
        start_demand = 1'b0;
        run_target   = 3'd1;
        case (mode_select)
            2'b10: begin
                start_demand = (diff >= 8'd1);
                run_target   = 3'd4;
            end
            2'b11: begin
                start_demand = (diff >= HYST_V);
                run_target   = 3'd2;
            end
            2'b01: begin
                start_demand = (diff >= HYST_V);
                if (diff <= 8'd4)      run_target = 3'd1;
                else if (diff <= 8'd6) run_target = 3'd2;
                else                   run_target = 3'd3;
            end
            default: begin
                start_demand = 1'b0;
                run_target   = 3'd1;
            end
        endcase
    end

    always_comb begin
        case (state_q)
            S_PRESTART: fan_target = 3'd1;
            S_RUN:      fan_target = run_target;
            S_RUNDOWN:  fan_target = 3'd1;
            default:    fan_target = 3'd0;
        endcase
    end

    // Sequencer: every timed state restarts the shared counter on entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_demand) state_d = S_PRESTART;
            end
            S_PRESTART: begin
                if (!start_demand) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == PRE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RUN: begin
                // Off (mode 00) bypasses the min-on hold; a thermostat stop waits for it.
                if (stop_cond && (min_on_done || mode_select == 2'b00)) begin
                    state_d = S_RUNDOWN;
                    cnt_d   = '0;
                end else if (!min_on_done) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RUNDOWN: begin
                if (cnt_q == RD_LAST) begin
                    state_d = S_LOCKOUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_LOCKOUT: begin
                if (cnt_q == LO_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Fan ramp: the counter keeps running across target changes while out of step.
    always_comb begin
        fan_d  = fan_q;
        ramp_d = '0;
        if (fan_q != fan_target) begin
            if (ramp_q == RAMP_LAST) begin
                ramp_d = '0;
                fan_d  = (fan_q < fan_target) ? (fan_q + 3'd1) : (fan_q - 3'd1);
            end else begin
                ramp_d = ramp_q + 16'd1;
            end
        end
    end

    // Registered from the next state so the output is a clean flop.
    assign comp_d = (state_d == S_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ramp_q  <= '0;
            fan_q   <= 3'd0;
            comp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ramp_q  <= ramp_d;
            fan_q   <= fan_d;
            comp_q  <= comp_d;
        end
    end

    assign compressor_on = comp_q;
    assign fan_speed     = fan_q;
    assign seq_state     = state_q;

endmodule
